approx_error_monitor: RTL and testbench
=======================================

Name: approx_error_monitor

Overview:
Sequential checker that consumes paired exact/approximate multiplier results and accumulates error statistics over a fixed window of samples. It is the measurement end of the exact-vs-approximate comparison flow: stimulus drives both arithmetic variants, and this block reduces their outputs to error count, summed absolute error, and peak absolute error. It is used in simulation and on-chip characterisation of clock-gated approximate multipliers.

Parameters:
WIDTH, 16, bit width of exact_in/approx_in (unsigned products)
SAMPLES, 256, number of accepted sample pairs per measurement window (>=1)
CNT_W, 16, width of err_count and sample_count (must hold SAMPLES)
ACC_W, 32, width of sum_abs_err accumulator

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a new window (sampled in IDLE or DONE)
in_valid  input  1  exact_in/approx_in pair valid
in_ready  output  1  block accepts a pair this cycle
exact_in  input  WIDTH  exact result
approx_in  input  WIDTH  approximate result
busy  output  1  high in ACCUM state
done  output  1  high in DONE state; results final
sample_count  output  CNT_W  pairs accepted in current window
err_count  output  CNT_W  pairs with exact_in != approx_in
sum_abs_err  output  ACC_W  saturating sum of |exact_in - approx_in|
max_abs_err  output  WIDTH  largest |exact_in - approx_in| seen
sat  output  1  sticky: sum_abs_err clamped this window

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; all outputs 0 (in_ready, busy, done, sample_count, err_count, sum_abs_err, max_abs_err, sat). Reset mid-window discards all progress; no partial results retained.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0. start=1 -> clear all statistics to 0, go ACCUM next cycle.
- ACCUM: in_ready=1, busy=1. Handshake = in_valid & in_ready at rising edge; a pair is accepted exactly once per such edge. start ignored in ACCUM.
- Per accepted pair, at the same edge: diff = |exact_in - approx_in|, computed with WIDTH+1-bit subtraction, result WIDTH bits unsigned (max 2^WIDTH-1). sample_count += 1; err_count += 1 if diff != 0; sum_abs_err += zero-extended diff, clamped to 2^ACC_W-1 with sat set to 1 on clamp (sat then sticky until next start/rst); max_abs_err = max(max_abs_err, diff).
- Outputs reflect an accepted pair on the cycle after its handshake edge (1-cycle latency), then hold until next accepted pair.
- Window end: the edge accepting pair number SAMPLES moves state to DONE; that pair is included. in_ready drops the following cycle; no further pair accepted.
- DONE: done=1, busy=0, in_ready=0, all statistics frozen. start=1 -> clear statistics, go ACCUM (done falls next cycle). Without start, DONE holds indefinitely.
- in_valid in IDLE/DONE is ignored (no accept, no state change).
- exact_in == approx_in: counts toward sample_count only; diff=0 never changes max/sum.
- approx_in > exact_in handled symmetrically (absolute value).
- SAMPLES=1: single accepted pair moves ACCUM->DONE.
- Counters never wrap: sample_count <= SAMPLES by construction; err_count <= sample_count.
- rst takes priority over start and handshake at the same edge.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, start=1 -> all outputs 0, state IDLE, in_ready=0.
- Basic window (SAMPLES=4): start, then pairs (100,100),(100,96),(50,57),(0,0) -> done=1, sample_count=4, err_count=2, sum_abs_err=11, max_abs_err=7, sat=0.
- Backpressure gaps: same 4 pairs with in_valid low 3 cycles between each -> identical results; sample_count increments only on in_valid&in_ready edges.
- Saturation (ACC_W=17, WIDTH=16, SAMPLES=4): pairs (65535,0) x3 -> sum_abs_err=131071 clamped, sat=1, max_abs_err=65535; sat stays 1 through DONE.
- Reset mid-window: start, accept 2 pairs, assert rst -> all statistics 0, IDLE; new start then 4 error-free pairs -> err_count=0, done=1.
- Restart and ignore: start asserted during ACCUM ignored (counts continue); in DONE, start clears stats and re-enters ACCUM; in_valid in DONE not accepted (sample_count stays 4).

Source files
------------

// File: rtl/approx_error_monitor.sv
// approx_error_monitor
//   Reduces a stream of paired exact/approximate multiplier results to error
//   statistics over a window of SAMPLES accepted pairs: number of mismatching
//   pairs, saturating sum of absolute error, and peak absolute error.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          synchronous active-high reset
//   start        begin a new window (honoured in IDLE or DONE)
//   in_valid     exact_in/approx_in pair valid
//   in_ready     pair accepted on a rising edge where in_valid is also high
//   exact_in     exact product
//   approx_in    approximate product
//   busy         window in progress
//   done         window complete, statistics final
//   sample_count pairs accepted in the current window
//   err_count    pairs with exact_in != approx_in
//   sum_abs_err  saturating sum of |exact_in - approx_in|
//   max_abs_err  largest |exact_in - approx_in| seen
//   sat          sticky, sum_abs_err was clamped this window
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | after reset, waiting for start
// ACCUM | accepting pairs, statistics updating
// DONE  | window complete, statistics frozen until start

module approx_error_monitor #(
    parameter int WIDTH   = 16,
    parameter int SAMPLES = 256,
    parameter int CNT_W   = 16,
    parameter int ACC_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] exact_in,
    input  logic [WIDTH-1:0] approx_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [WIDTH-1:0] max_abs_err,
    output logic             sat
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic             clear;
    logic             accept;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] diff;
    logic [ACC_W:0]   sum_ext;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        clear      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // the pair accepted at this edge is the last one of the window
                if (in_valid && sample_count == LAST_IDX) state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    clear      = 1'b1;
                    state_next = S_ACCUM;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // A borrow out of the WIDTH+1-bit subtraction means approx_in > exact_in;
    // the magnitude always fits in WIDTH bits so negating the low bits suffices.
    assign sub_w   = {1'b0, exact_in} - {1'b0, approx_in};
    assign diff    = sub_w[WIDTH] ? (~sub_w[WIDTH-1:0] + WIDTH'(1)) : sub_w[WIDTH-1:0];
    assign sum_ext = {1'b0, sum_abs_err} + {{(ACC_W + 1 - WIDTH){1'b0}}, diff};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sample_count <= '0;
            err_count    <= '0;
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
            sat          <= 1'b0;
        end else if (accept) begin
            sample_count <= sample_count + CNT_W'(1);
            if (diff != '0) err_count <= err_count + CNT_W'(1);
            if (sum_ext[ACC_W]) begin
                sum_abs_err <= '1;
                sat         <= 1'b1;
            end else begin
                sum_abs_err <= sum_ext[ACC_W-1:0];
            end
            if (diff > max_abs_err) max_abs_err <= diff;
        end
    end

endmodule

// File: tb/tb_approx_error_monitor.sv
module tb_approx_error_monitor;

    localparam int WIDTH   = 16;
    localparam int SAMPLES = 4;
    localparam int CNT_W   = 16;
    localparam int ACC_W   = 17;
    localparam longint SUM_MAX = (longint'(1) << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] exact_in;
    logic [WIDTH-1:0] approx_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] sum_abs_err;
    logic [WIDTH-1:0] max_abs_err;
    logic             sat;

    approx_error_monitor #(
        .WIDTH(WIDTH), .SAMPLES(SAMPLES), .CNT_W(CNT_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .exact_in(exact_in), .approx_in(approx_in),
        .busy(busy), .done(done), .sample_count(sample_count),
        .err_count(err_count), .sum_abs_err(sum_abs_err),
        .max_abs_err(max_abs_err), .sat(sat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: window phase plus plain integer statistics.
    localparam int PH_IDLE = 0, PH_ACCUM = 1, PH_DONE = 2;
    int     m_phase = PH_IDLE;
    int     m_cnt = 0, m_err = 0, m_max = 0;
    longint m_sum = 0;
    bit     m_sat = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_err = 0; m_max = 0; m_sum = 0; m_sat = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit v, input int e, input int a);
        int d;
        if (r) begin
            m_phase = PH_IDLE;
            model_clear();
        end else if (m_phase == PH_ACCUM) begin
            if (v) begin
                d = (e > a) ? e - a : a - e;
                m_cnt++;
                if (d != 0) m_err++;
                m_sum += d;
                if (m_sum > SUM_MAX) begin
                    m_sum = SUM_MAX;
                    m_sat = 1'b1;
                end
                if (d > m_max) m_max = d;
                if (m_cnt == SAMPLES) m_phase = PH_DONE;
            end
        end else if (s) begin
            model_clear();
            m_phase = PH_ACCUM;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/in_ready"},     64'(in_ready),     64'(m_phase == PH_ACCUM));
        chk({tag, "/busy"},         64'(busy),         64'(m_phase == PH_ACCUM));
        chk({tag, "/done"},         64'(done),         64'(m_phase == PH_DONE));
        chk({tag, "/sample_count"}, 64'(sample_count), 64'(m_cnt));
        chk({tag, "/err_count"},    64'(err_count),    64'(m_err));
        chk({tag, "/sum_abs_err"},  64'(sum_abs_err),  64'(m_sum));
        chk({tag, "/max_abs_err"},  64'(max_abs_err),  64'(m_max));
        chk({tag, "/sat"},          64'(sat),          64'(m_sat));
    endtask

    task automatic cyc(input string tag, input bit r, input bit s, input bit v,
                       input int e, input int a);
        rst       = r;
        start     = s;
        in_valid  = v;
        exact_in  = WIDTH'(e);
        approx_in = WIDTH'(a);
        @(posedge clk);
        model_step(r, s, v, e, a);
        #1;
        check_all(tag);
    endtask

    int basic_e[4] = '{100, 100, 50, 0};
    int basic_a[4] = '{100, 96, 57, 0};

    initial begin
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; exact_in = '0; approx_in = '0;

        // reset with start and in_valid held high
        cyc("reset", 1, 1, 1, 5, 3);
        cyc("reset", 1, 1, 1, 5, 3);
        cyc("idle",  0, 0, 1, 5, 3);
        chk("reset_ready", 64'(in_ready), 64'(0));

        // basic window
        cyc("basic_start", 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("basic", 0, 0, 1, basic_e[i], basic_a[i]);
        cyc("basic_hold", 0, 0, 1, 9, 1);
        chk("basic_done", 64'(done), 64'(1));
        chk("basic_cnt",  64'(sample_count), 64'(4));
        chk("basic_err",  64'(err_count), 64'(2));
        chk("basic_sum",  64'(sum_abs_err), 64'(11));
        chk("basic_max",  64'(max_abs_err), 64'(7));
        chk("basic_sat",  64'(sat), 64'(0));

        // same pairs with gaps of three idle cycles
        cyc("gap_start", 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 3; g++) cyc("gap_idle", 0, 0, 0, 1234, 1);
            cyc("gap", 0, 0, 1, basic_e[i], basic_a[i]);
        end
        chk("gap_cnt", 64'(sample_count), 64'(4));
        chk("gap_sum", 64'(sum_abs_err), 64'(11));
        chk("gap_max", 64'(max_abs_err), 64'(7));

        // saturation of the 17-bit sum
        cyc("sat_start", 0, 1, 0, 0, 0);
        cyc("sat", 0, 0, 1, 65535, 0);
        cyc("sat", 0, 0, 1, 0, 65535);
        chk("sat_below", 64'(sat), 64'(0));
        cyc("sat", 0, 0, 1, 65535, 0);
        chk("sat_clamp", 64'(sum_abs_err), 64'(131071));
        chk("sat_set",   64'(sat), 64'(1));
        cyc("sat", 0, 0, 1, 7, 7);
        for (int i = 0; i < 3; i++) cyc("sat_done", 0, 0, 0, 0, 0);
        chk("sat_sticky", 64'(sat), 64'(1));
        chk("sat_max",    64'(max_abs_err), 64'(65535));

        // reset in mid-window, then an error-free window
        cyc("mid_start", 0, 1, 0, 0, 0);
        cyc("mid", 0, 0, 1, 10, 3);
        cyc("mid", 0, 0, 1, 3, 10);
        cyc("mid_rst", 1, 0, 1, 3, 10);
        chk("mid_rst_cnt", 64'(sample_count), 64'(0));
        chk("mid_rst_sum", 64'(sum_abs_err), 64'(0));
        cyc("mid_idle", 0, 0, 1, 3, 10);
        cyc("clean_start", 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("clean", 0, 0, 1, 1000 * i, 1000 * i);
        chk("clean_err",  64'(err_count), 64'(0));
        chk("clean_done", 64'(done), 64'(1));

        // in_valid in DONE ignored, start in DONE restarts, start in ACCUM ignored
        for (int i = 0; i < 3; i++) cyc("done_valid", 0, 0, 1, 40, 2);
        chk("done_valid_cnt", 64'(sample_count), 64'(4));
        cyc("restart", 0, 1, 1, 40, 2);
        chk("restart_clear", 64'(sample_count), 64'(0));
        cyc("re", 0, 0, 1, 20, 25);
        cyc("re_start", 0, 1, 1, 30, 21);
        chk("accum_start_ignored", 64'(sample_count), 64'(2));
        cyc("re", 0, 1, 0, 0, 0);
        cyc("re", 0, 0, 1, 8, 8);
        cyc("re", 0, 0, 1, 1, 2);
        chk("re_done", 64'(done), 64'(1));
        chk("re_sum",  64'(sum_abs_err), 64'(15));

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int  e, a, sel;
            bit  r, s, v;
            r   = ($urandom_range(0, 149) == 0);
            s   = (m_phase == PH_ACCUM) ? ($urandom_range(0, 9) == 0)
                                        : ($urandom_range(0, 2) == 0);
            v   = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 3);
            e   = $urandom_range(0, 65535);
            a   = $urandom_range(0, 65535);
            if (sel == 0) a = e;
            else if (sel == 1) begin
                e = $urandom_range(0, 1) ? 65535 : 0;
                a = 65535 - e;
            end
            cyc("rand", r, s, v, e, a);
        end

        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
